// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM states, mux codes, control word.
// Optional feature: MC_BNE_EN adds the BNEEX state for bne support.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
`ifdef MC_BNE_EN
    ,S_BNEEX  = 4'd13
`endif
  } state_t;

  // pcwrite/irwrite in FETCH are qualified by mem_ready (ready_gate); branches are qualified by zero.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       ready_gate;
    logic       branch;
    logic       branch_inv;
  } ctrl_t;

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic retires(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: retires = 1'b1;
`ifdef MC_BNE_EN
      S_BNEEX: retires = 1'b1;
`endif
      default: retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle MIPS main controller.
// master: the controller; slave: the datapath side that supplies op/zero/mem_ready.
interface mc_main_ctrl_if #(parameter int CNT_W = 32);

  logic [5:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             memwrite;
  logic             irwrite;
  logic             iord;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, memwrite, irwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal, instr_cnt
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, memwrite, irwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal, instr_cnt
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Purely combinational Moore decode of controller state into the raw control word.
// Optional feature: MC_BNE_EN decodes BNEEX like BEQEX with an inverted branch condition.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req    = 1'b1;
        cw.irwrite    = 1'b1;
        cw.alusrcb    = SRCB_FOUR;
        cw.aluop      = ALUOP_ADD;
        cw.pcsrc      = PCSRC_ALU;
        cw.pcwrite    = 1'b1;
        cw.ready_gate = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req  = 1'b1;
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        cw.alusrca    = 1'b1;
        cw.alusrcb    = SRCB_B;
        cw.aluop      = ALUOP_SUB;
        cw.pcsrc      = PCSRC_ALUOUT;
        cw.branch     = 1'b1;
        cw.branch_inv = 1'b1;
      end
`endif
      S_ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      S_JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state, pcen gating, illegal flag, retire counter.
// Optional feature: define MC_BNE_EN to support bne (op 000101); otherwise bne is reported illegal.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_main_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  ctrl_t            cw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // op is only consulted in DECODE and MEMADR; memory states hold until mem_ready.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        case (bus.op)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
`ifdef MC_BNE_EN
      S_BNEEX:   state_d = S_FETCH;
`endif
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  assign retire = retires(state_q) && (state_d == S_FETCH);

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .cw    (cw)
  );

  assign bus.mem_req   = cw.mem_req;
  assign bus.memwrite  = cw.memwrite;
  assign bus.irwrite   = cw.irwrite & bus.mem_ready;
  assign bus.iord      = cw.iord;
  assign bus.regwrite  = cw.regwrite;
  assign bus.regdst    = cw.regdst;
  assign bus.memtoreg  = cw.memtoreg;
  assign bus.alusrca   = cw.alusrca;
  assign bus.alusrcb   = cw.alusrcb;
  assign bus.aluop     = cw.aluop;
  assign bus.pcsrc     = cw.pcsrc;
  // zero is used combinationally so the branch resolves in the same cycle as the compare.
  assign bus.pcen      = (cw.pcwrite & (bus.mem_ready | ~cw.ready_gate))
                       | (cw.branch & (bus.zero ^ cw.branch_inv));
  assign bus.illegal   = illegal_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for mc_main_ctrl, built with a 4-bit counter so wraparound is reachable.
// Follows MC_BNE_EN the same way as the RTL.
module tb_mc_main_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  // {mem_req,memwrite,irwrite,iord}_{regwrite,regdst,memtoreg,alusrca}_{alusrcb,aluop}_{pcsrc,pcen,illegal}
  localparam logic [15:0] W_IDLE      = 16'b0000_0000_0000_0000;
  localparam logic [15:0] W_FETCH     = 16'b1010_0000_0100_0010;
  localparam logic [15:0] W_FETCHWAIT = 16'b1000_0000_0100_0000;
  localparam logic [15:0] W_FETCHILL  = 16'b1010_0000_0100_0011;
  localparam logic [15:0] W_DECODE    = 16'b0000_0000_1100_0000;
  localparam logic [15:0] W_MEMADR    = 16'b0000_0001_1000_0000;
  localparam logic [15:0] W_MEMRD     = 16'b1001_0000_0000_0000;
  localparam logic [15:0] W_MEMWB     = 16'b0000_1010_0000_0000;
  localparam logic [15:0] W_MEMWR     = 16'b1101_0000_0000_0000;
  localparam logic [15:0] W_RTYPEEX   = 16'b0000_0001_0010_0000;
  localparam logic [15:0] W_RTYPEWB   = 16'b0000_1100_0000_0000;
  localparam logic [15:0] W_BRTAKEN   = 16'b0000_0001_0001_0110;
  localparam logic [15:0] W_BRNOT     = 16'b0000_0001_0001_0100;
  localparam logic [15:0] W_ADDIEX    = 16'b0000_0001_1000_0000;
  localparam logic [15:0] W_ADDIWB    = 16'b0000_1000_0000_0000;
  localparam logic [15:0] W_JEX       = 16'b0000_0000_0000_1010;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic             zero;
    logic             rdy;
    logic [15:0]      word;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_main_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_main_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] outWord();
    return {bus.mem_req, bus.memwrite, bus.irwrite, bus.iord,
            bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
            bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcen, bus.illegal};
  endfunction

  task automatic addVec(input string nm, input logic [5:0] o, input logic z, input logic r,
                        input logic [15:0] w, input int c);
    vec_t v;
    v.name = nm; v.op = o; v.zero = z; v.rdy = r; v.word = w; v.cnt = CNT_W'(c);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic z, input logic r);
    bus.op        = o;
    bus.zero      = z;
    bus.mem_ready = r;
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] w, input logic [CNT_W-1:0] c);
    logic [15:0] got;
    got = outWord();
    checks++;
    if (got !== w) begin
      errors++;
      $display("[TB] FAIL %s controls: got %b expected %b", nm, got, w);
    end
    checks++;
    if (bus.instr_cnt !== c) begin
      errors++;
      $display("[TB] FAIL %s instr_cnt: got %0d expected %0d", nm, bus.instr_cnt, c);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    addVec("idle",        T_R,    1'b0, 1'b1, W_IDLE,      0);
    addVec("r_fetch",     T_R,    1'b0, 1'b1, W_FETCH,     0);
    addVec("r_decode",    T_R,    1'b0, 1'b1, W_DECODE,    0);
    addVec("r_ex",        T_R,    1'b0, 1'b1, W_RTYPEEX,   0);
    addVec("r_wb",        T_R,    1'b0, 1'b1, W_RTYPEWB,   0);
    addVec("lw_fetch",    T_LW,   1'b0, 1'b1, W_FETCH,     1);
    addVec("lw_decode",   T_LW,   1'b0, 1'b1, W_DECODE,    1);
    addVec("lw_memadr",   T_LW,   1'b0, 1'b1, W_MEMADR,    1);
    addVec("lw_memrd0",   T_LW,   1'b0, 1'b0, W_MEMRD,     1);
    addVec("lw_memrd1",   T_LW,   1'b0, 1'b0, W_MEMRD,     1);
    addVec("lw_memrd2",   T_LW,   1'b0, 1'b0, W_MEMRD,     1);
    addVec("lw_memrd3",   T_LW,   1'b0, 1'b1, W_MEMRD,     1);
    addVec("lw_memwb",    T_LW,   1'b0, 1'b1, W_MEMWB,     1);
    addVec("sw_fwait",    T_SW,   1'b0, 1'b0, W_FETCHWAIT, 2);
    addVec("sw_fetch",    T_SW,   1'b0, 1'b1, W_FETCH,     2);
    addVec("sw_decode",   T_SW,   1'b0, 1'b1, W_DECODE,    2);
    addVec("sw_memadr",   T_SW,   1'b0, 1'b1, W_MEMADR,    2);
    addVec("sw_memwr",    T_SW,   1'b0, 1'b1, W_MEMWR,     2);
    addVec("beqt_fetch",  T_BEQ,  1'b1, 1'b1, W_FETCH,     3);
    addVec("beqt_decode", T_BEQ,  1'b1, 1'b1, W_DECODE,    3);
    addVec("beqt_ex",     T_BEQ,  1'b1, 1'b1, W_BRTAKEN,   3);
    addVec("beqn_fetch",  T_BEQ,  1'b0, 1'b1, W_FETCH,     4);
    addVec("beqn_decode", T_BEQ,  1'b0, 1'b1, W_DECODE,    4);
    addVec("beqn_ex",     T_BEQ,  1'b0, 1'b1, W_BRNOT,     4);
    addVec("addi_fetch",  T_ADDI, 1'b0, 1'b1, W_FETCH,     5);
    addVec("addi_decode", T_ADDI, 1'b0, 1'b1, W_DECODE,    5);
    addVec("addi_ex",     T_ADDI, 1'b0, 1'b1, W_ADDIEX,    5);
    addVec("addi_wb",     T_ADDI, 1'b0, 1'b1, W_ADDIWB,    5);
    addVec("bad_fetch",   T_BAD,  1'b0, 1'b1, W_FETCH,     6);
    addVec("bad_decode",  T_BAD,  1'b0, 1'b1, W_DECODE,    6);
    addVec("j_fetch_ill", T_J,    1'b0, 1'b1, W_FETCHILL,  6);
    addVec("j_decode",    T_J,    1'b0, 1'b1, W_DECODE,    6);
    addVec("j_ex",        T_J,    1'b0, 1'b1, W_JEX,       6);
    addVec("bne_fetch",   T_BNE,  1'b0, 1'b1, W_FETCH,     7);
    addVec("bne_decode",  T_BNE,  1'b0, 1'b1, W_DECODE,    7);

    applyStimulus(T_R, 1'b0, 1'b1);
    #12;
    checkOutput("reset", W_IDLE, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].zero, vecs[i].rdy);
      @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].word, vecs[i].cnt);
      step();
    end

    // bne: either executes and retires, or is flagged illegal and dropped.
`ifdef MC_BNE_EN
    applyStimulus(T_BNE, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bne_ex", W_BRTAKEN, 7);
    step();
    applyStimulus(T_SW, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bne_retired", W_FETCH, 8);
    exp_cnt = 8;
`else
    applyStimulus(T_SW, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bne_illegal", W_FETCHILL, 7);
    exp_cnt = 7;
`endif

    // Asynchronous reset while a store is stalled in MEMWR.
    step();
    @(negedge clk);
    checkOutput("sw2_decode", W_DECODE, exp_cnt);
    step();
    step();
    applyStimulus(T_SW, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sw2_memwr_hold", W_MEMWR, exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_memwr", W_IDLE, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Retire 16 jumps to walk the 4-bit counter through 15 and back to 0.
    applyStimulus(T_J, 1'b0, 1'b1);
    step();
    for (int n = 0; n < 15; n++) begin
      step();
      step();
      step();
    end
    @(negedge clk);
    checkOutput("cnt_max", W_FETCH, 15);
    step();
    step();
    step();
    @(negedge clk);
    checkOutput("cnt_wrap", W_FETCH, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
